ram_framebuffer: RTL and testbench
==================================

Name: ram_framebuffer

Overview:
Parametrised successor to the CPU data RAM with video read port. The block holds CPU data memory and a memory-mapped 1-bit-per-pixel screen region. It provides:
- a CPU read/write port with synchronous read;
- a pipelined video port that returns both the addressed word and the single pixel bit;
- an out-of-range flag for pixels outside the screen;
- a hardware clear/fill engine that writes a value over the whole screen region in the background.

It sits between the CPU datapath and the VGA pixel generator.

Parameters:
- WIDTH, 16, word width in bits; must be a power of 2.
- REGISTER_COUNT, 1024, memory depth in words.
- RAM_SCREEN_OFFSET, 512, first word of the screen region.
- BITS_PER_MEMORY_PIXEL_X, 3, log2 of horizontal screen pixels per memory bit.
- BITS_PER_MEMORY_PIXEL_Y, 3, log2 of vertical screen pixels per memory bit.
- SCREEN_X_BITS, 9, log2 of mapped screen width in pixels (512).
- SCREEN_Y_BITS, 9, log2 of mapped screen height in pixels (512).
- Derived: WORDS_PER_LINE = 2^SCREEN_X_BITS >> (log2(WIDTH)+BITS_PER_MEMORY_PIXEL_X), which is 4 at defaults.
- Derived: SCREEN_WORDS = WORDS_PER_LINE * (2^SCREEN_Y_BITS >> BITS_PER_MEMORY_PIXEL_Y), which is 256 at defaults.
- Constraint: RAM_SCREEN_OFFSET+SCREEN_WORDS <= REGISTER_COUNT.

Ports:
- CPUclk  in  1  the only clock, rising edge.
- reset  in  1  synchronous, active-high.
- addr  in  $clog2(REGISTER_COUNT)  CPU word address.
- wdata  in  WIDTH  CPU write data.
- we  in  1  CPU write enable.
- rdata  out  WIDTH  CPU read data.
- pixel_x  in  10  current screen column.
- pixel_y  in  10  current screen row.
- pixel_out  out  WIDTH  screen word containing the pixel.
- pixel_bit  out  1  selected pixel value.
- pixel_valid  out  1  pixel lies inside the mapped screen.
- clear_start  in  1  start the fill engine.
- fill_value  in  WIDTH  word written by the fill engine.
- clear_busy  out  1  fill engine running.
- clear_done  out  1  one-cycle pulse when the fill completes.

Behaviour:
- Clock and reset: one clock, CPUclk. Reset is synchronous and active-high on port reset.
- Reset values: rdata=0, pixel_out=0, pixel_bit=0, pixel_valid=0, clear_busy=0, clear_done=0, FSM=IDLE. Memory contents are not cleared by reset.
- CPU port, latency: rdata is registered and appears 1 cycle after addr.
- CPU port, read-during-write: read-first. Same-cycle write and read of one address returns the old data.
- CPU port, out-of-range address: if addr >= REGISTER_COUNT, the write is ignored and rdata is 0.
- Video pipeline, stage 1 registers three values:
  - word index = RAM_SCREEN_OFFSET + (pixel_y>>BITS_PER_MEMORY_PIXEL_Y)*WORDS_PER_LINE + (pixel_x>>(log2(WIDTH)+BITS_PER_MEMORY_PIXEL_X));
  - bit index = WIDTH-1-((pixel_x>>BITS_PER_MEMORY_PIXEL_X) mod WIDTH), so the MSB is the leftmost pixel;
  - valid = (pixel_x < 2^SCREEN_X_BITS) && (pixel_y < 2^SCREEN_Y_BITS).
- Video pipeline, stage 2 registers:
  - pixel_out = memory[word index];
  - pixel_bit = pixel_out[bit index];
  - pixel_valid.
- Video latency: total latency is 2 cycles from pixel_x/pixel_y to the outputs. When valid=0, pixel_out=0 and pixel_bit=0 with the same latency.
- Video read-during-write: video reads are read-first against a same-cycle write.
- Fill engine, single write port: the CPU write and the fill write share one write port.
- Fill FSM, IDLE: clear_start=1 latches fill_value, sets ptr=0, sets clear_busy=1 next cycle, and goes to CLEAR.
- Fill FSM, CLEAR, no CPU write: each cycle writes the latched fill to RAM_SCREEN_OFFSET+ptr and increments ptr.
- Fill FSM, CLEAR, CPU write that cycle: the CPU has priority, the engine stalls, and ptr holds.
- Fill FSM, CLEAR exit: after the write at ptr=SCREEN_WORDS-1, go to DONE.
- Fill FSM, DONE: clear_done=1 and clear_busy=0 for one cycle, then go to IDLE.
- clear_start handling: clear_start is ignored in CLEAR and DONE.
- Fill timing: the minimum fill is SCREEN_WORDS busy cycles; each stall adds 1.
- CPU writes during a fill:
  - to a word already filled, the CPU value persists;
  - to a word not yet filled, the CPU value is overwritten by fill.
- Reset mid-fill: the FSM goes to IDLE, clear_busy=0 the next cycle, and clear_done is not pulsed. Already-written words keep the fill value.
- The engine never writes outside [RAM_SCREEN_OFFSET, RAM_SCREEN_OFFSET+SCREEN_WORDS-1].

Test Plan:
- CPU read-first: write addr 5=16'hA5A5, then on the same cycle write 16'h1234 to and read addr 5. Required: rdata=A5A5. The next read of addr 5 returns 1234.
- Video pixel select: write addr 521=16'h0040, then drive (x=200, y=20). Required: 2 cycles later pixel_out=0040, pixel_bit=1 (bit 6), pixel_valid=1. Driving (208, 20) gives bit 5, so pixel_bit=0.
- Out-of-range pixel: drive (600, 20). Required: 2 cycles later pixel_valid=0, pixel_out=0, pixel_bit=0.
- Full fill: pulse clear_start with fill_value=16'hFFFF and no CPU traffic. Required: clear_busy high for exactly 256 cycles, then a single clear_done pulse. Addrs 512..767 read FFFF; addrs 511 and 768 are unchanged.
- Fill with CPU traffic: start a fill, then issue CPU writes to addr 100 on 10 cycles and pulse clear_start mid-fill. Required: busy lasts 266 cycles, addr 100 holds the CPU data, and there is only one done pulse.
- Reset mid-fill: assert reset after 10 CLEAR cycles. Required: clear_busy=0 next cycle and no clear_done. Addrs 512..521 hold the fill value; addr 522 is unchanged.

Source files
------------

// File: rtl/ram_framebuffer_if.sv
// Bus bundle between the CPU/VGA side and the framebuffer RAM.
// It carries the CPU port, the video port and the fill-engine controls.
interface ram_framebuffer_if #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 10
) ();
    logic [ADDR_BITS-1:0] addr;
    logic [WIDTH-1:0]     wdata;
    logic                 we;
    logic [WIDTH-1:0]     rdata;
    logic [9:0]           pixel_x;
    logic [9:0]           pixel_y;
    logic [WIDTH-1:0]     pixel_out;
    logic                 pixel_bit;
    logic                 pixel_valid;
    logic                 clear_start;
    logic [WIDTH-1:0]     fill_value;
    logic                 clear_busy;
    logic                 clear_done;

    modport master (
        output addr, wdata, we, pixel_x, pixel_y, clear_start, fill_value,
        input  rdata, pixel_out, pixel_bit, pixel_valid, clear_busy, clear_done
    );

    modport slave (
        input  addr, wdata, we, pixel_x, pixel_y, clear_start, fill_value,
        output rdata, pixel_out, pixel_bit, pixel_valid, clear_busy, clear_done
    );
endinterface

// File: rtl/ram_framebuffer.sv
// CPU data RAM with a 1-bit-per-pixel screen region, a 2-stage video read port
// and a background fill engine that shares the single write port with the CPU.
module ram_framebuffer #(
    parameter int WIDTH                   = 16,
    parameter int REGISTER_COUNT          = 1024,
    parameter int RAM_SCREEN_OFFSET       = 512,
    parameter int BITS_PER_MEMORY_PIXEL_X = 3,
    parameter int BITS_PER_MEMORY_PIXEL_Y = 3,
    parameter int SCREEN_X_BITS           = 9,
    parameter int SCREEN_Y_BITS           = 9
) (
    input  logic               CPUclk,
    input  logic               reset,
    ram_framebuffer_if.slave   bus
);
    localparam int AW             = $clog2(REGISTER_COUNT);
    localparam int WB             = $clog2(WIDTH);
    localparam int WORDS_PER_LINE = (1 << SCREEN_X_BITS) >> (WB + BITS_PER_MEMORY_PIXEL_X);
    localparam int SCREEN_WORDS   = WORDS_PER_LINE * ((1 << SCREEN_Y_BITS) >> BITS_PER_MEMORY_PIXEL_Y);
    localparam int PW             = $clog2(SCREEN_WORDS);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} fill_state_t;

    logic [WIDTH-1:0] mem [REGISTER_COUNT];

    fill_state_t      state;
    logic [PW-1:0]    ptr;
    logic [WIDTH-1:0] fill_q;

    logic             addr_ok;
    logic             cpu_write;
    logic             fill_write;
    logic [AW-1:0]    fill_addr;

    logic [AW-1:0]    vidx_c;
    logic [WB-1:0]    bidx_c;
    logic             valid_c;
    logic [AW-1:0]    vidx_q;
    logic [WB-1:0]    bidx_q;
    logic             valid_q;

    assign addr_ok    = (32'(bus.addr) < 32'(REGISTER_COUNT));
    assign cpu_write  = bus.we && addr_ok;
    // The CPU owns the write port whenever it writes; the engine simply stalls.
    assign fill_write = (state == CLEAR) && !cpu_write && !reset;
    assign fill_addr  = AW'(RAM_SCREEN_OFFSET + 32'(ptr));

    assign vidx_c  = AW'(RAM_SCREEN_OFFSET
                     + 32'(bus.pixel_y >> BITS_PER_MEMORY_PIXEL_Y) * WORDS_PER_LINE
                     + 32'(bus.pixel_x >> (WB + BITS_PER_MEMORY_PIXEL_X)));
    // MSB is the leftmost pixel, so the bit index is the inverted column offset.
    assign bidx_c  = ~bus.pixel_x[BITS_PER_MEMORY_PIXEL_X +: WB];
    assign valid_c = (32'(bus.pixel_x) < (32'd1 << SCREEN_X_BITS))
                  && (32'(bus.pixel_y) < (32'd1 << SCREEN_Y_BITS));

    always_ff @(posedge CPUclk) begin
        if (cpu_write)
            mem[bus.addr] <= bus.wdata;
        else if (fill_write)
            mem[fill_addr] <= fill_q;
    end

    always_ff @(posedge CPUclk) begin
        if (reset) begin
            bus.rdata       <= '0;
            vidx_q          <= '0;
            bidx_q          <= '0;
            valid_q         <= 1'b0;
            bus.pixel_out   <= '0;
            bus.pixel_bit   <= 1'b0;
            bus.pixel_valid <= 1'b0;
        end else begin
            bus.rdata       <= addr_ok ? mem[bus.addr] : '0;
            vidx_q          <= vidx_c;
            bidx_q          <= bidx_c;
            valid_q         <= valid_c;
            bus.pixel_out   <= valid_q ? mem[vidx_q] : '0;
            bus.pixel_bit   <= valid_q & mem[vidx_q][bidx_q];
            bus.pixel_valid <= valid_q;
        end
    end

    always_ff @(posedge CPUclk) begin
        if (reset) begin
            state          <= IDLE;
            ptr            <= '0;
            fill_q         <= '0;
            bus.clear_busy <= 1'b0;
            bus.clear_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.clear_done <= 1'b0;
                    if (bus.clear_start) begin
                        fill_q         <= bus.fill_value;
                        ptr            <= '0;
                        bus.clear_busy <= 1'b1;
                        state          <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (!cpu_write) begin
                        ptr <= ptr + 1'b1;
                        if (ptr == PW'(SCREEN_WORDS - 1)) begin
                            bus.clear_busy <= 1'b0;
                            bus.clear_done <= 1'b1;
                            state          <= DONE;
                        end
                    end
                end
                DONE: begin
                    bus.clear_done <= 1'b0;
                    state          <= IDLE;
                end
                default: begin
                    bus.clear_busy <= 1'b0;
                    bus.clear_done <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_framebuffer.sv
// Directed bench for ram_framebuffer: CPU port, video pixel select and fill engine.
module tb_ram_framebuffer;
    logic CPUclk = 1'b0;
    logic reset  = 1'b1;

    int checks   = 0;
    int failures = 0;

    ram_framebuffer_if #(.WIDTH(16), .ADDR_BITS(10)) bus ();

    ram_framebuffer dut (
        .CPUclk (CPUclk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 CPUclk = ~CPUclk;

    task automatic tick();
        @(posedge CPUclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [9:0] a, input logic [15:0] d, input logic w);
        bus.addr  = a;
        bus.wdata = d;
        bus.we    = w;
        tick();
        bus.we    = 1'b0;
    endtask

    task automatic cpuRead(input logic [9:0] a, output logic [15:0] d);
        bus.addr = a;
        bus.we   = 1'b0;
        tick();
        d = bus.rdata;
    endtask

    task automatic videoAt(input logic [9:0] x, input logic [9:0] y);
        bus.pixel_x = x;
        bus.pixel_y = y;
        tick();
        tick();
    endtask

    logic [15:0] rd;
    int          busyCnt;
    int          doneCnt;
    int          bad;
    int          guard;

    initial begin
        bus.addr        = '0;
        bus.wdata       = '0;
        bus.we          = 1'b0;
        bus.pixel_x     = '0;
        bus.pixel_y     = '0;
        bus.clear_start = 1'b0;
        bus.fill_value  = '0;

        tick();
        tick();
        checkOutput("rst_rdata", 32'(bus.rdata), 0);
        checkOutput("rst_pixel_out", 32'(bus.pixel_out), 0);
        checkOutput("rst_pixel_bit", 32'(bus.pixel_bit), 0);
        checkOutput("rst_pixel_valid", 32'(bus.pixel_valid), 0);
        checkOutput("rst_busy", 32'(bus.clear_busy), 0);
        checkOutput("rst_done", 32'(bus.clear_done), 0);
        reset = 1'b0;

        // CPU read-first behaviour
        applyStimulus(10'd5, 16'hA5A5, 1'b1);
        applyStimulus(10'd5, 16'h1234, 1'b1);
        checkOutput("read_first", 32'(bus.rdata), 32'hA5A5);
        cpuRead(10'd5, rd);
        checkOutput("read_after_write", 32'(rd), 32'h1234);

        // Video pixel select and boundaries
        applyStimulus(10'd521, 16'h0040, 1'b1);
        applyStimulus(10'd767, 16'h0001, 1'b1);
        videoAt(10'd200, 10'd20);
        checkOutput("vid_word", 32'(bus.pixel_out), 32'h0040);
        checkOutput("vid_bit6", 32'(bus.pixel_bit), 1);
        checkOutput("vid_valid", 32'(bus.pixel_valid), 1);
        videoAt(10'd208, 10'd20);
        checkOutput("vid_bit5", 32'(bus.pixel_bit), 0);
        checkOutput("vid_word2", 32'(bus.pixel_out), 32'h0040);
        videoAt(10'd511, 10'd511);
        checkOutput("vid_corner_word", 32'(bus.pixel_out), 32'h0001);
        checkOutput("vid_corner_bit", 32'(bus.pixel_bit), 1);
        videoAt(10'd600, 10'd20);
        checkOutput("vid_oor_valid", 32'(bus.pixel_valid), 0);
        checkOutput("vid_oor_word", 32'(bus.pixel_out), 0);
        checkOutput("vid_oor_bit", 32'(bus.pixel_bit), 0);
        videoAt(10'd0, 10'd512);
        checkOutput("vid_oor_y", 32'(bus.pixel_valid), 0);

        // Full fill with no CPU traffic
        applyStimulus(10'd511, 16'h1111, 1'b1);
        applyStimulus(10'd768, 16'h2222, 1'b1);
        bus.fill_value  = 16'hFFFF;
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        busyCnt = 0;
        guard   = 0;
        while (bus.clear_busy && guard < 1000) begin
            busyCnt++;
            guard++;
            tick();
        end
        checkOutput("fill_busy_cycles", 32'(busyCnt), 256);
        checkOutput("fill_done_pulse", 32'(bus.clear_done), 1);
        tick();
        checkOutput("fill_done_single", 32'(bus.clear_done), 0);
        bad = 0;
        for (int a = 512; a < 768; a++) begin
            cpuRead(10'(a), rd);
            if (rd !== 16'hFFFF) bad++;
        end
        checkOutput("fill_words", 32'(bad), 0);
        cpuRead(10'd511, rd);
        checkOutput("fill_below", 32'(rd), 32'h1111);
        cpuRead(10'd768, rd);
        checkOutput("fill_above", 32'(rd), 32'h2222);

        // Fill with CPU writes and an ignored mid-fill start
        bus.fill_value = 16'h5555;
        busyCnt = 0;
        doneCnt = 0;
        for (int i = 0; i < 400; i++) begin
            bus.clear_start = (i == 0) || (i == 50);
            bus.fill_value  = (i == 50) ? 16'h0000 : 16'h5555;
            bus.we          = (i >= 20) && (i < 30);
            bus.addr        = 10'd100;
            bus.wdata       = 16'hBE00 + 16'(i);
            tick();
            if (bus.clear_busy) busyCnt++;
            if (bus.clear_done) doneCnt++;
        end
        bus.we          = 1'b0;
        bus.clear_start = 1'b0;
        checkOutput("stall_busy_cycles", 32'(busyCnt), 266);
        checkOutput("stall_done_count", 32'(doneCnt), 1);
        cpuRead(10'd100, rd);
        checkOutput("stall_cpu_word", 32'(rd), 32'hBE1D);
        cpuRead(10'd700, rd);
        checkOutput("stall_fill_latched", 32'(rd), 32'h5555);

        // Reset in the middle of a fill
        applyStimulus(10'd522, 16'h3333, 1'b1);
        bus.fill_value  = 16'hA0A0;
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        repeat (10) tick();
        checkOutput("mid_busy_before", 32'(bus.clear_busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("mid_busy_after", 32'(bus.clear_busy), 0);
        doneCnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.clear_done) doneCnt++;
            tick();
        end
        checkOutput("mid_no_done", 32'(doneCnt), 0);
        cpuRead(10'd512, rd);
        checkOutput("mid_first_word", 32'(rd), 32'hA0A0);
        cpuRead(10'd521, rd);
        checkOutput("mid_last_word", 32'(rd), 32'hA0A0);
        cpuRead(10'd522, rd);
        checkOutput("mid_untouched", 32'(rd), 32'h3333);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
